leiwand_rv32_uart_tx: RTL and testbench

Memory-mapped UART transmitter for the leiwand_rv32 SoC. It sits on the core's valid/ready memory bus next to `leiwand_rv32_simple_mem` and acts as its bus peer: the address decoder gates `valid` for the peripheral window. It buffers bytes written by the core and serialises them as 8N1 frames on `tx`. A programmable divisor sets the bit time.

---
 rtl/leiwand_rv32_uart_tx.sv | 244 ++++++++++++++++++++++++
 tb/tb_leiwand_rv32_uart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_uart_tx.sv
// ============================================================================
// Module   : leiwand_rv32_uart_tx
// Function : Memory-mapped 8N1 UART transmitter for the leiwand_rv32 SoC.
//            It is a valid/ready bus peer and has a TX FIFO (or a single
//            holding register) and a programmable bit divisor.
// Options  : UART_TX_FIFO_EN - defined: FIFO_DEPTH-entry FIFO;
//                              undefined: single holding register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module leiwand_rv32_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  output logic                 ready,
  input  logic [`XLEN/8-1:0]   wen,
  input  logic [`XLEN-1:0]     addr,
  input  logic [`XLEN-1:0]     wdata,
  output logic [`XLEN-1:0]     rdata,
  output logic                 tx,
  output logic                 irq
);

  localparam logic [0:0] BUS_IDLE = 1'b0;
  localparam logic [0:0] BUS_RESP = 1'b1;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic [0:0]       r_bus_state, w_bus_next;
  logic [1:0]       r_tx_state, w_tx_next;
  logic [`XLEN-1:0] r_rdata, w_rdata_nxt;
  logic [15:0]      r_div;
  logic             r_ovf;
  logic [15:0]      r_cnt;
  logic [2:0]       r_bitn;
  logic [7:0]       r_shreg;

  logic       w_acc, w_rd, w_push, w_push_ok, w_pop, w_ovf_set, w_ovf_clr;
  logic [1:0] w_sel;
  logic       w_full, w_empty, w_busy, w_bit_end;
  logic [7:0] w_level, w_head;

  logic w_unused;
  assign w_unused = ^{addr[`XLEN-1:4], addr[1:0], wdata[`XLEN-1:16], wen[`XLEN/8-1:2]};

  // --------------------------------------------------------------------------
  // Bus access decode; side effects commit on the edge that leaves IDLE
  // --------------------------------------------------------------------------
  assign w_acc     = (r_bus_state == BUS_IDLE) && valid;
  assign w_rd      = (wen == '0);
  assign w_sel     = addr[3:2];
  assign w_push    = w_acc && (w_sel == 2'd0) && wen[0];
  // A pop on the same edge frees a slot, so a push into a full buffer survives
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = w_acc && (w_sel == 2'd1) && wen[0] && wdata[3];

  // Read mux, sampled into r_rdata at the accepting edge
  always_comb begin
    w_rdata_nxt = '0;
    if (w_rd) begin
      case (w_sel)
        2'd1:    w_rdata_nxt = {{(`XLEN-16){1'b0}}, w_level, 4'b0000, r_ovf, w_empty, w_full, w_busy};
        2'd2:    w_rdata_nxt = {{(`XLEN-16){1'b0}}, r_div};
        default: w_rdata_nxt = '0;
      endcase
    end
  end

  // Bus FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bus_state <= BUS_IDLE;
    else      r_bus_state <= w_bus_next;
  end

  // Bus FSM next state: RESP always lasts exactly one cycle
  always_comb begin
    w_bus_next = r_bus_state;
    case (r_bus_state)
      BUS_IDLE: if (valid) w_bus_next = BUS_RESP;
      default:  w_bus_next = BUS_IDLE;
    endcase
  end

  // Bus FSM outputs: rdata is forced to zero outside the response cycle
  always_comb begin
    ready = (r_bus_state == BUS_RESP);
    rdata = (r_bus_state == BUS_RESP) ? r_rdata : '0;
  end

  // Read data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_rdata <= '0;
    else if (w_acc) r_rdata <= w_rdata_nxt;
  end

  // Divisor register, byte-writable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= DEFAULT_DIV;
    end else if (w_acc && (w_sel == 2'd2)) begin
      if (wen[0]) r_div[7:0]  <= wdata[7:0];
      if (wen[1]) r_div[15:8] <= wdata[15:8];
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // --------------------------------------------------------------------------
  // Transmit buffer
  // --------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= wdata[7:0];
  end

  assign w_head  = r_mem[r_rptr];
  assign w_full  = (r_count == FIFO_DEPTH[AW:0]);
  assign w_empty = (r_count == '0);
  assign w_level = 8'(r_count);
`else
  logic [7:0] r_hold;
  logic       r_hold_vld;
  logic       w_unused_depth;
  assign w_unused_depth = (FIFO_DEPTH != 0);

  // Single holding register stands in for the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      if (w_push_ok)  r_hold <= wdata[7:0];
      if (w_push_ok)  r_hold_vld <= 1'b1;
      else if (w_pop) r_hold_vld <= 1'b0;
    end
  end

  assign w_head  = r_hold;
  assign w_full  = r_hold_vld;
  assign w_empty = !r_hold_vld;
  assign w_level = {7'd0, r_hold_vld};
`endif

  // --------------------------------------------------------------------------
  // Transmit serialiser
  // --------------------------------------------------------------------------
  assign w_bit_end = (r_cnt == 16'd0);
  // Pop when idle, or back-to-back at the end of a stop bit
  assign w_pop = !w_empty && ((r_tx_state == TX_IDLE) ||
                              ((r_tx_state == TX_STOP) && w_bit_end));

  // TX FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tx_state <= TX_IDLE;
    else      r_tx_state <= w_tx_next;
  end

  // TX FSM next state: each bit ends when the countdown reaches zero
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (!w_empty) w_tx_next = TX_START;
      TX_START: if (w_bit_end) w_tx_next = TX_DATA;
      TX_DATA:  if (w_bit_end && (r_bitn == 3'd7)) w_tx_next = TX_STOP;
      default:  if (w_bit_end) w_tx_next = w_empty ? TX_IDLE : TX_START;
    endcase
  end

  // TX FSM outputs: line level follows the state so reset forces it high
  always_comb begin
    w_busy = (r_tx_state != TX_IDLE);
    case (r_tx_state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = r_shreg[0];
      default:  tx = 1'b1;
    endcase
  end

  assign irq = w_empty && !w_busy;

  // Bit timer and shifter; the divisor is sampled only at bit boundaries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
    end else if (w_pop) begin
      r_shreg <= w_head;
      r_cnt   <= r_div;
      r_bitn  <= '0;
    end else if (r_tx_state != TX_IDLE) begin
      if (w_bit_end) begin
        r_cnt <= r_div;
        if (r_tx_state == TX_DATA) begin
          r_shreg <= {1'b0, r_shreg[7:1]};
          r_bitn  <= r_bitn + 3'd1;
        end
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_leiwand_rv32_uart_tx.sv
// ============================================================================
// Module   : tb_leiwand_rv32_uart_tx
// Function : Self-checking bench for leiwand_rv32_uart_tx. A frame-level
//            model (byte queue, 10-bit frame list, per-bit clock budget)
//            predicts every output each cycle; literal checks pin the model.
// Options  : UART_TX_FIFO_EN selects the buffer depth the model assumes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leiwand_rv32_uart_tx;

`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, tx, irq;
  logic [31:0] rdata;

  int n_err = 0;
  int n_chk = 0;

  leiwand_rv32_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .wen(wen),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  bit          m_resp;
  logic [31:0] m_rdata;
  bit          m_active;
  logic [9:0]  m_bits;
  int          m_idx, m_left;
  logic [15:0] m_div;
  bit          m_ovf;

  task automatic model_reset();
    q.delete();
    m_resp = 0; m_rdata = 0; m_active = 0; m_bits = '1;
    m_idx = 0; m_left = 0; m_div = 16'd867; m_ovf = 0;
  endtask

  task automatic model_step();
    int          lvl;
    logic [15:0] pdiv;
    bit          push, clr, pop, b_empty, b_full;
    logic [7:0]  b;
    lvl = q.size(); pdiv = m_div; push = 0; clr = 0; pop = 0;
    b_empty = (lvl == 0); b_full = (lvl == DEPTH);
    if (m_resp) begin
      m_resp = 0; m_rdata = 0;
    end else if (valid) begin
      m_resp = 1; m_rdata = 0;
      if (wen == 4'h0) begin
        if (addr[3:2] == 2'd1)
          m_rdata = {16'h0, 8'(lvl), 4'h0, m_ovf, b_empty, b_full, m_active};
        else if (addr[3:2] == 2'd2)
          m_rdata = {16'h0, m_div};
      end
      push = (addr[3:2] == 2'd0) && wen[0];
      clr  = (addr[3:2] == 2'd1) && wen[0] && wdata[3];
      if (addr[3:2] == 2'd2 && wen[0]) m_div[7:0]  = wdata[7:0];
      if (addr[3:2] == 2'd2 && wen[1]) m_div[15:8] = wdata[15:8];
    end
    // serial side: a frame is 10 bits each lasting DIV+1 clocks
    if (m_active) begin
      m_left--;
      if (m_left == 0) begin
        m_idx++;
        if (m_idx == 10) begin
          m_active = 0;
          if (lvl > 0) pop = 1;
        end else begin
          m_left = int'(pdiv) + 1;
        end
      end
    end else if (lvl > 0) begin
      pop = 1;
    end
    if (pop) begin
      b = q.pop_front();
      m_bits = {1'b1, b, 1'b0};
      m_idx = 0; m_left = int'(pdiv) + 1; m_active = 1;
    end
    if (push) begin
      if (lvl < DEPTH || pop) q.push_back(wdata[7:0]);
      else m_ovf = 1;
    end
    if (clr) m_ovf = 0;
  endtask

  // Model advances on every clock edge and on reset assertion
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("tx",    {31'd0, tx},    {31'd0, (m_active ? m_bits[m_idx] : 1'b1)});
      chk("irq",   {31'd0, irq},   {31'd0, (q.size() == 0) && !m_active});
      chk("ready", {31'd0, ready}, {31'd0, m_resp});
      chk("rdata", rdata,          m_resp ? m_rdata : 32'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic acc(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d,
                     output logic [31:0] rd, output logic rdy);
    @(negedge clk); #1;
    valid = 1'b1; addr = {28'h0, a, 2'b00}; wen = w; wdata = d;
    @(negedge clk);
    rd = rdata; rdy = ready;
    #1 valid = 1'b0; wen = 4'h0;
  endtask

  task automatic hold(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d, input int n);
    @(negedge clk); #1;
    valid = 1'b1; addr = {28'h0, a, 2'b00}; wen = w; wdata = d;
    repeat (n) @(negedge clk);
    #1 valid = 1'b0; wen = 4'h0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(irq === 1'b1) && k < budget) begin
      @(negedge clk); k++;
    end
    n_chk++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL wait_idle: irq still %b after %0d cycles, expected 1", irq, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        rdy;
    int          fall_seen, irq_at;
    logic [9:0]  exp_frame;
    logic [1:0]  ra;
    logic [3:0]  rw;
    logic [31:0] rdt;
    int unsigned r;

    repeat (3) @(negedge clk);
    chk("reset_tx",  {31'd0, tx},  32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);
    #1 rst = 1'b1;

    // Reset values
    acc(2'd1, 4'h0, 32'h0, rd, rdy);
    chk("reset_status", rd, 32'h0000_0004);
    chk("reset_ready",  {31'd0, rdy}, 32'd1);
    acc(2'd2, 4'h0, 32'h0, rd, rdy);
    chk("reset_div", rd, 32'd867);

    // DIV=3, then 0xA5: sample each bit one clock into it
    acc(2'd2, 4'h3, 32'd3, rd, rdy);
    acc(2'd0, 4'h1, 32'hA5, rd, rdy);
    fall_seen = 0;
    for (int k = 0; k < 10 && !fall_seen; k++) begin
      if (tx === 1'b0) fall_seen = 1;
      else @(negedge clk);
    end
    chk("a5_tx_fall", fall_seen, 1);
    exp_frame = 10'b1_1010_0101_0;
    irq_at = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if ((k % 4) == 1 && (k / 4) < 10)
        chk($sformatf("a5_bit%0d", k / 4), {31'd0, tx}, {31'd0, exp_frame[k / 4]});
      if (irq === 1'b1 && irq_at < 0) irq_at = k;
    end
    chk("a5_frame_len", irq_at, 40);

    // Overflow and clear
    acc(2'd2, 4'h3, 32'd1, rd, rdy);
`ifdef UART_TX_FIFO_EN
    for (int i = 0; i < 10; i++) acc(2'd0, 4'h1, 32'(8'h30 + i), rd, rdy);
    acc(2'd1, 4'h0, 32'h0, rd, rdy);
    chk("ovf_status", rd, 32'h0000_080B);
    acc(2'd1, 4'h1, 32'h8, rd, rdy);
    acc(2'd1, 4'h0, 32'h0, rd, rdy);
    chk("ovf_cleared", rd, 32'h0000_0701);
`else
    acc(2'd0, 4'h1, 32'h11, rd, rdy);
    acc(2'd0, 4'h1, 32'h22, rd, rdy);
    acc(2'd0, 4'h1, 32'h33, rd, rdy);
    acc(2'd1, 4'h0, 32'h0, rd, rdy);
    chk("ovf_status", rd, 32'h0000_010B);
    acc(2'd1, 4'h1, 32'h8, rd, rdy);
    acc(2'd1, 4'h0, 32'h0, rd, rdy);
    chk("ovf_cleared", rd, 32'h0000_0103);
`endif
    wait_idle(2000);

    // DIV change mid-bit, then asynchronous reset mid-frame
    acc(2'd0, 4'h1, 32'h3C, rd, rdy);
    repeat (5) @(negedge clk);
    acc(2'd2, 4'h3, 32'd7, rd, rdy);
    acc(2'd0, 4'h1, 32'h5A, rd, rdy);
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx",    {31'd0, tx},    32'd1);
    chk("async_rst_irq",   {31'd0, irq},   32'd1);
    chk("async_rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk); #1 rst = 1'b1;
    acc(2'd1, 4'h0, 32'h0, rd, rdy);
    chk("post_rst_status", rd, 32'h0000_0004);
    acc(2'd2, 4'h0, 32'h0, rd, rdy);
    chk("post_rst_div", rd, 32'd867);

    // Randomised traffic with short bit times
    acc(2'd2, 4'h3, 32'd0, rd, rdy);
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      ra  = 2'($urandom_range(0, 3));
      rw  = (r < 30) ? 4'h0 : 4'($urandom);
      rdt = $urandom;
      if (ra == 2'd2) rdt = {24'h0, 8'($urandom_range(0, 4))};
      if (r < 10) hold(ra, rw, rdt, int'($urandom_range(2, 3)));
      else        acc(ra, rw, rdt, rd, rdy);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (r == 99) wait_idle(2000);
    end
    wait_idle(5000);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
